// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: scan results, debounce FSM states
// and the row/column to hex legend map of the Pmod KYPD layout.
package keypad_pkg;

   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_KEY   = 2'd1,
      RES_MULTI = 2'd2
   } res_kind_t;

   // code is only meaningful for RES_KEY and is kept at zero otherwise so results compare cleanly
   typedef struct packed {
      res_kind_t  kind;
      logic [3:0] code;
   } scan_res_t;

   typedef enum logic {
      ST_RELEASED = 1'b0,
      ST_PRESSED  = 1'b1
   } kp_state_t;

   localparam scan_res_t RES_IDLE = '{kind: RES_NONE, code: 4'h0};

   // indexed by {row, col}; row 0 = 1 2 3 A, row 1 = 4 5 6 B, row 2 = 7 8 9 C, row 3 = 0 F E D
   localparam logic [15:0][3:0] KEY_MAP = {
      4'hD, 4'hE, 4'hF, 4'h0,
      4'hC, 4'h9, 4'h8, 4'h7,
      4'hB, 4'h6, 4'h5, 4'h4,
      4'hA, 4'h3, 4'h2, 4'h1
   };

   function automatic logic [3:0] key_legend(input logic [1:0] row, input logic [1:0] col);
      return KEY_MAP[{row, col}];
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-scan stability counter and press/release FSM; accepted key registered one cycle after scan_done.
// No backpressure: key_valid is a single-cycle pulse the consumer must take when it appears.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scan_done,
   input  scan_res_t  scan_res,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);

   kp_state_t  state_q;
   kp_state_t  state_d;
   scan_res_t  prev_res;
   logic [3:0] stab_cnt;
   logic [3:0] cnt_next;
   logic       stable;
   logic       is_key;
   logic       is_none;
   logic       load_code;

   // A MULTI result also breaks a run because it differs from any KEY or NONE result
   assign cnt_next = (scan_res == prev_res)
                   ? ((stab_cnt >= CNT_MAX) ? CNT_MAX : stab_cnt + 4'd1)
                   : 4'd1;
   assign stable   = scan_done && (cnt_next == CNT_MAX);
   assign is_key   = (scan_res.kind == RES_KEY);
   assign is_none  = (scan_res.kind == RES_NONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_res <= RES_IDLE;
         stab_cnt <= 4'd0;
      end else if (scan_done) begin
         prev_res <= scan_res;
         stab_cnt <= cnt_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_RELEASED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RELEASED: if (stable && is_key)  state_d = ST_PRESSED;
         ST_PRESSED:  if (stable && is_none) state_d = ST_RELEASED;
         default:     state_d = ST_RELEASED;
      endcase
   end

   // Roll-over to a different key reloads the code; the same key held longer stays silent
   always_comb begin
      load_code = 1'b0;
      case (state_q)
         ST_RELEASED: load_code = stable && is_key;
         ST_PRESSED:  load_code = stable && is_key && (scan_res.code != key_code);
         default:     load_code = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_valid <= 1'b0;
         key_code  <= 4'h0;
      end else begin
         key_valid <= load_code;
         if (load_code) begin
            key_code <= scan_res.code;
         end
      end
   end

   assign key_held = (state_q == ST_PRESSED);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner: synchronizes rows, strobes columns, reduces each full scan to NONE/KEY/MULTI.
// Key pulse one cycle after the column-3 sample that completes debounce; no backpressure.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 6250,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int                SLOT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [1:0]        COL_LAST  = 2'(NUM_COLS - 1);

   logic [NUM_ROWS-1:0] row_meta;
   logic [NUM_ROWS-1:0] row_sync;
   logic [SLOT_W-1:0]   slot_cnt;
   logic [1:0]          col_idx;
   logic                slot_last;
   logic                scan_done;

   logic [1:0]          acc_hits;
   logic [3:0]          acc_code;
   logic [2:0]          col_hits;
   logic [1:0]          col_row;
   logic [2:0]          hit_sum;
   logic [1:0]          merged_hits;
   logic [3:0]          merged_code;
   scan_res_t           scan_res;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_meta <= '1;
         row_sync <= '1;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
      end
   end

   assign slot_last = (slot_cnt == SLOT_LAST);
   assign scan_done = slot_last && (col_idx == COL_LAST);

   // col_out is registered so the strobe moves on the cycle after the sample
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_cnt <= '0;
         col_idx  <= 2'd0;
         col_out  <= 4'b1110;
      end else if (slot_last) begin
         slot_cnt <= '0;
         col_idx  <= col_idx + 2'd1;
         col_out  <= ~(4'b0001 << (col_idx + 2'd1));
      end else begin
         slot_cnt <= slot_cnt + SLOT_W'(1);
      end
   end

   // Hit count saturates at 2: beyond one hit the scan is MULTI regardless of how many
   always_comb begin
      col_hits = 3'd0;
      col_row  = 2'd0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (!row_sync[r]) begin
            col_hits = col_hits + 3'd1;
            col_row  = 2'(r);
         end
      end
      hit_sum     = 3'(acc_hits) + col_hits;
      merged_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
      merged_code = (acc_hits == 2'd0 && col_hits == 3'd1) ? key_legend(col_row, col_idx) : acc_code;

      scan_res = RES_IDLE;
      if (merged_hits == 2'd1) begin
         scan_res = '{kind: RES_KEY, code: merged_code};
      end else if (merged_hits == 2'd2) begin
         scan_res.kind = RES_MULTI;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_hits <= 2'd0;
         acc_code <= 4'h0;
      end else if (scan_done) begin
         acc_hits <= 2'd0;
         acc_code <= 4'h0;
      end else if (slot_last) begin
         acc_hits <= merged_hits;
         acc_code <= merged_code;
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .scan_done (scan_done),
      .scan_res  (scan_res),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives rows from the column strobes; expected key
// pulses are queued when a press is applied and checked (code, held, latency) as they appear.
module tb_keypad_scanner;

   localparam int SCAN_DIV = 8;
   localparam int DEB      = 3;
   localparam int SCAN_CYC = 4 * SCAN_DIV;

   typedef struct {
      logic [3:0] code;
      int         cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;

   logic [15:0] pressed = '0;
   exp_t        exp_q[$];
   exp_t        mon_e;
   int          mon_lat;
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          vld_cnt = 0;
   int          held_drops = 0;
   bit          watch_held = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // key at (r,c) pulls row r low while column c is strobed
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
         end
      end
   end

   keypad_scanner #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp_v);
      end
   endtask

   task automatic expect_key(input logic [3:0] code);
      exp_q.push_back('{code: code, cyc: cyc});
   endtask

   // returns just after the edge where col_out wraps 0111 -> 1110 (a scan just completed)
   task automatic wait_scan_start();
      logic [3:0] prev;
      int         n;
      bit         ok;
      prev = col_out;
      n    = 0;
      ok   = 1'b0;
      while (!ok && n < 4 * SCAN_CYC) begin
         @(posedge clk);
         #1;
         n++;
         ok   = (col_out == 4'b1110) && (prev == 4'b0111);
         prev = col_out;
      end
      if (!ok) chk("scan_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_scans(input int n);
      for (int i = 0; i < n; i++) wait_scan_start();
   endtask

   task automatic chk_reset_outputs();
      chk("rst_col_out",   32'(col_out),   32'h0000_000E);
      chk("rst_key_code",  32'(key_code),  32'd0);
      chk("rst_key_valid", 32'(key_valid), 32'd0);
      chk("rst_key_held",  32'(key_held),  32'd0);
   endtask

   always @(negedge clk) begin
      if (watch_held && !key_held) held_drops++;
      if (key_valid) begin
         vld_cnt++;
         if (exp_q.size() == 0) begin
            chk("spurious_vld", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e   = exp_q.pop_front();
            mon_lat = cyc - mon_e.cyc;
            chk("vld_key_code", 32'(key_code), 32'(mon_e.code));
            chk("vld_key_held", 32'(key_held), 32'd1);
            chk("vld_latency_window",
                32'(mon_lat >= DEB * SCAN_CYC - SCAN_DIV && mon_lat <= (DEB + 1) * SCAN_CYC + 4), 32'd1);
         end
      end
   end

   initial begin
      int         base;
      int         drop_base;
      int         n;
      logic [3:0] prev_col;
      logic [3:0] exp_col;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst_n = 1'b1;

      // idle column rotation and slot length
      wait_scan_start();
      exp_col = 4'b1110;
      for (int i = 0; i < 4; i++) begin
         exp_col  = {exp_col[2:0], exp_col[3]};
         prev_col = col_out;
         n        = 0;
         do begin
            @(posedge clk);
            #1;
            n++;
         end while (col_out == prev_col && n < 4 * SCAN_DIV);
         chk("col_period", 32'(n), 32'(SCAN_DIV));
         chk("col_value",  32'(col_out), 32'(exp_col));
      end
      wait_scans(10);
      chk("idle_no_vld", 32'(vld_cnt), 32'd0);
      chk("idle_held",   32'(key_held), 32'd0);

      // single press of "5", then release
      base    = vld_cnt;
      pressed = 16'(1) << 5;
      expect_key(4'h5);
      wait_scans(5);
      chk("press5_pulses", 32'(vld_cnt - base), 32'd1);
      chk("press5_held",   32'(key_held), 32'd1);
      chk("press5_code",   32'(key_code), 32'h5);
      pressed = '0;
      wait_scans(2);
      chk("release_held_2scans", 32'(key_held), 32'd1);
      wait_scans(1);
      chk("release_held_3scans", 32'(key_held), 32'd0);

      // bouncing "9" then steady
      base = vld_cnt;
      for (int i = 0; i < 4; i++) begin
         pressed = (i % 2 == 0) ? (16'(1) << 10) : 16'(0);
         wait_scans(1);
      end
      chk("bounce_no_vld", 32'(vld_cnt - base), 32'd0);
      pressed = 16'(1) << 10;
      expect_key(4'h9);
      wait_scans(5);
      chk("bounce9_pulses", 32'(vld_cnt - base), 32'd1);
      pressed = '0;
      wait_scans(4);
      chk("bounce9_released", 32'(key_held), 32'd0);

      // "A" and "D" together, then "D" released
      base    = vld_cnt;
      pressed = (16'(1) << 3) | (16'(1) << 15);
      wait_scans(5);
      chk("multi_no_vld", 32'(vld_cnt - base), 32'd0);
      chk("multi_held",   32'(key_held), 32'd0);
      pressed = 16'(1) << 3;
      expect_key(4'hA);
      wait_scans(5);
      chk("multi_a_pulses", 32'(vld_cnt - base), 32'd1);
      pressed = pressed | (16'(1) << 15);
      wait_scans(4);
      chk("multi_pressed_held", 32'(key_held), 32'd1);
      chk("multi_pressed_code", 32'(key_code), 32'hA);
      pressed = 16'(1) << 3;
      wait_scans(4);
      chk("same_key_no_repeat", 32'(vld_cnt - base), 32'd1);
      pressed = '0;
      wait_scans(4);
      chk("multi_released", 32'(key_held), 32'd0);

      // roll-over "1" -> "E" without a NONE scan
      base    = vld_cnt;
      pressed = 16'(1) << 0;
      expect_key(4'h1);
      wait_scans(5);
      chk("roll_first_held", 32'(key_held), 32'd1);
      drop_base  = held_drops;
      watch_held = 1'b1;
      pressed    = 16'(1) << 14;
      expect_key(4'hE);
      wait_scans(5);
      watch_held = 1'b0;
      chk("roll_pulses",    32'(vld_cnt - base), 32'd2);
      chk("roll_held_drop", 32'(held_drops - drop_base), 32'd0);
      chk("roll_code",      32'(key_code), 32'hE);
      pressed = '0;
      wait_scans(4);
      chk("roll_released", 32'(key_held), 32'd0);

      // reset pulse two scans into the debounce of "7"
      pressed = 16'(1) << 8;
      wait_scans(2);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk_reset_outputs();
      rst_n = 1'b1;
      base  = vld_cnt;
      expect_key(4'h7);
      wait_scans(5);
      chk("rst7_pulses", 32'(vld_cnt - base), 32'd1);
      chk("rst7_held",   32'(key_held), 32'd1);
      pressed = '0;
      wait_scans(4);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad (Digilent Pmod KYPD layout) and delivers debounced hex key codes to the calculator datapath. This is the input-side counterpart to the multiplexed 7-segment display driver: it strobes one column at a time, samples the rows, resolves one key per full scan and emits a one-cycle `key_valid` pulse per accepted press. It sits between the board Pmod pins and the operand/mode registers of the calculator top.

## Interface
- `SCAN_DIV`, 6250: clk cycles per column slot (1/16 ms at 100 MHz); legal range ≥ 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to accept a press or release; legal range 1–15.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `row_in` input 4: keypad rows, active-low, externally pulled up, asynchronous.
- `col_out` output 4: column strobes, active-low, exactly one low at all times.
- `key_code` output 4: hex legend of the last accepted key.
- `key_valid` output 1: one-cycle pulse when `key_code` updates.
- `key_held` output 1: high while the accepted key remains debounced-pressed.

## Operation
- Legend map, row r / column c: r0 = 1,2,3,A; r1 = 4,5,6,B; r2 = 7,8,9,C; r3 = 0,F,E,D.
- `row_in` passes through a 2-flop synchronizer before any use.
- Slot counter counts 0..`SCAN_DIV`-1. On the last cycle of each slot, the synchronized rows are sampled for the current column, then the column index advances, wrapping from 3 to 0.
- Scan result after column 3 is sampled, one of: NONE (no row low in any column), KEY(code) (exactly one row/column hit), or MULTI (two or more hits).
- Stability counter, saturating at `DEBOUNCE_SCANS`: increments when the scan result equals the previous scan result; otherwise it reloads to 1.
- RELEASED state: a KEY result reaching count `DEBOUNCE_SCANS` loads `key_code`, pulses `key_valid`, sets `key_held`, and moves to PRESSED.
- PRESSED state:
  - NONE stable for `DEBOUNCE_SCANS` clears `key_held` and returns to RELEASED.
  - A different KEY stable for `DEBOUNCE_SCANS` (roll-over) loads the new code and pulses `key_valid` again; the state stays PRESSED.
  - The same KEY produces no further pulses; there is no auto-repeat.
- MULTI is never accepted. It holds the current state and outputs unchanged and breaks the stability run.

## Timing
- Reset values: `col_out` = 4'b1110, `key_code` = 0, `key_valid` = 0, `key_held` = 0. Slot counter, column index and stability counter are 0; previous result is NONE; state is RELEASED.
- Reset asserted mid-scan or mid-debounce aborts everything. Scanning restarts at column 0, slot 0 on the first cycle after `rst_n` rises.
- Column change is registered: `col_out` changes on the cycle after the sampling cycle. This gives rows `SCAN_DIV`-1 cycles to settle before the next sample.
- Full scan period = 4 × `SCAN_DIV` cycles.
- `key_valid` and `key_held` assert on the cycle after the column-3 sample that completes the `DEBOUNCE_SCANS`-th stable scan.
- Press-to-pulse latency is between `DEBOUNCE_SCANS` and `DEBOUNCE_SCANS`+1 scans, plus 2 synchronizer cycles.
- `key_code` is stable whenever `key_valid` is high and holds its value until the next accepted key.

## Structure
- Shared package `keypad_pkg` contains:
  - `NUM_COLS` = 4 and `NUM_ROWS` = 4;
  - the scan-result typedef (NONE/KEY/MULTI plus a 4-bit code);
  - the FSM state typedef (RELEASED/PRESSED);
  - the row/column-to-legend constant map.
- One sub-module, `keypad_debounce`: it takes the per-scan result and a scan-done strobe and owns the stability counter and FSM.
- Column drive, slot counter, synchronizer and hit accumulation live in the top module.

## Test plan
The bench runs with `SCAN_DIV` = 8 and `DEBOUNCE_SCANS` = 3.
- Reset then idle: `col_out` cycles 1110→1101→1011→0111 every 8 cycles; no `key_valid` over 10 scans.
- Press "5" (row1 low while col1 strobed), held for 5 scans: exactly one `key_valid`, 3–4 scans after the press, with `key_code` = 4'h5 and `key_held` = 1. Release, then after 3 scans `key_held` = 0.
- Bounce "9": toggle it every scan for 4 scans, then hold it steady. No pulse during the bounce; exactly one pulse with `key_code` = 4'h9 after 3 stable scans.
- Hold "A" and "D" together: MULTI result, no pulse, `key_held` unchanged. Release "D": `key_code` = 4'hA pulses after 3 scans.
- Roll-over: hold "1" until accepted, then switch directly to "E" without a NONE scan. A second pulse occurs with `key_code` = 4'hE and `key_held` stays 1 throughout.
- Drop `rst_n` for 1 cycle while "7" is 2 scans into its debounce: all outputs return to reset values and `col_out` = 1110. "7" is then accepted 3–4 scans after `rst_n` rises.
